// File: rtl/program_loader_pkg.sv
// Shared types and constants for the framed instruction-memory loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT,
    ADR,
    HI,
    LO,
    WR,
    CSUM
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/program_loader.sv
// Receives a framed byte stream and writes 16-bit words into instruction
// memory while holding the CPU in reset; reports done or err at frame end.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         DATA_W    = 16,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ext_mem_wen,
  output logic [ADDR_W-1:0] ext_mem_addr,
  output logic [DATA_W-1:0] ext_mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  // Counter only needs to reach TIMEOUT-1; the expiring cycle is detected combinationally.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state, state_next;
  logic              hs;
  logic              timeout_hit;
  logic [TO_W-1:0]   timeout_cnt;
  logic [7:0]        csum;
  logic [7:0]        remaining;
  logic [ADDR_W-1:0] addr_ptr;
  logic [7:0]        hi_byte;

  assign in_ready = (state != WR);
  assign hs       = in_valid & in_ready;
  assign busy     = (state != IDLE);
  assign cpu_hold = (state != IDLE);

  assign timeout_hit = (TIMEOUT != 0) && (state != IDLE) && (state != WR) &&
                       !hs && (timeout_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (hs && in_data == SYNC_BYTE) state_next = CNT;
      CNT:  if (hs) state_next = ADR;
      ADR:  if (hs) state_next = HI;
      HI:   if (hs) state_next = LO;
      LO:   if (hs) state_next = WR;
      // remaining==1 marks the last word; COUNT=0 starts at 0 and runs 256 words.
      WR:   state_next = (remaining != 8'd1) ? HI : CSUM;
      CSUM: if (hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_mem_wen  <= 1'b0;
      ext_mem_addr <= '0;
      ext_mem_data <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      timeout_cnt  <= '0;
      csum         <= '0;
      remaining    <= '0;
      addr_ptr     <= '0;
      hi_byte      <= '0;
    end else begin
      ext_mem_wen <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;

      if (state == IDLE || state == WR || hs) begin
        timeout_cnt <= '0;
      end else begin
        timeout_cnt <= timeout_cnt + TO_W'(1);
      end

      case (state)
        IDLE: begin
          if (hs && in_data == SYNC_BYTE) begin
            err_code <= ERR_NONE;
            csum     <= '0;
          end
        end
        CNT: begin
          if (hs) begin
            remaining <= in_data;
            csum      <= csum + in_data;
          end
        end
        ADR: begin
          if (hs) begin
            addr_ptr <= ADDR_W'(in_data);
            csum     <= csum + in_data;
          end
        end
        HI: begin
          if (hs) begin
            hi_byte <= in_data;
            csum    <= csum + in_data;
          end
        end
        LO: begin
          if (hs) begin
            csum         <= csum + in_data;
            ext_mem_wen  <= 1'b1;
            ext_mem_addr <= addr_ptr;
            ext_mem_data <= DATA_W'({hi_byte, in_data});
          end
        end
        WR: begin
          addr_ptr  <= addr_ptr + ADDR_W'(1);
          remaining <= remaining - 8'd1;
        end
        CSUM: begin
          if (hs) begin
            if (in_data == csum) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end
        default: ;
      endcase

      if (timeout_hit) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: directed frames plus randomized frames checked against
// a frame-level reference model (expected writes, checksum outcome, latency).
module tb_program_loader;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ext_mem_wen;
  logic [7:0]  ext_mem_addr;
  logic [15:0] ext_mem_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;

  logic [7:0]  obsAddr[$];
  logic [15:0] obsData[$];
  int          obsCyc[$];
  int          doneCnt = 0;
  int          errCnt = 0;
  int          bothCnt = 0;
  int          busyCnt = 0;

  logic [7:0]  dataQ[$];

  program_loader #(
    .ADDR_W(8),
    .DATA_W(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .ext_mem_wen(ext_mem_wen),
    .ext_mem_addr(ext_mem_addr),
    .ext_mem_data(ext_mem_data),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: log every write strobe and count result pulses.
  always @(negedge clk) begin
    if (ext_mem_wen) begin
      obsAddr.push_back(ext_mem_addr);
      obsData.push_back(ext_mem_data);
      obsCyc.push_back(cyc);
    end
    if (done) doneCnt <= doneCnt + 1;
    if (err) errCnt <= errCnt + 1;
    if (done && err) bothCnt <= bothCnt + 1;
    if (busy) busyCnt <= busyCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, output int hsCyc);
    bit took;
    int guard;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    took  = 1'b0;
    guard = 0;
    hsCyc = -1;
    while (!took && guard < 40) begin
      @(negedge clk);
      took  = in_ready;
      hsCyc = cyc;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!took) checkOutput("handshake", 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] randData();
    if ($urandom % 4 == 0) return 8'hA5;
    return 8'($urandom);
  endfunction

  // Drives one frame built from cnt/base/dataQ and checks it against the model:
  // word i lands at (base+i) mod 256 with {byte 2i, byte 2i+1}, one cycle after
  // its low byte; checksum is the byte sum of COUNT, ADDR and data mod 256.
  task automatic applyStimulus(input logic [7:0] cnt, input logic [7:0] base,
                               input bit badCsum, input int maxGap);
    int nWords;
    int sum;
    int h;
    int obsBase;
    int doneBase;
    int errBase;
    int loCyc[$];
    logic [7:0] csumByte;

    nWords = (cnt == 8'd0) ? 256 : int'(cnt);
    sum = int'(cnt) + int'(base);
    for (int i = 0; i < 2 * nWords; i++) sum += int'(dataQ[i]);
    sum = sum % 256;
    csumByte = badCsum ? 8'((sum + 1) % 256) : 8'(sum);

    obsBase  = obsAddr.size();
    doneBase = doneCnt;
    errBase  = errCnt;

    sendByte(8'hA5, $urandom_range(0, maxGap), h);
    checkOutput("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    checkOutput("errcode_cleared", {30'd0, err_code}, 32'd0);
    sendByte(cnt, $urandom_range(0, maxGap), h);
    sendByte(base, $urandom_range(0, maxGap), h);
    for (int i = 0; i < 2 * nWords; i++) begin
      sendByte(dataQ[i], $urandom_range(0, maxGap), h);
      if (i % 2 == 1) loCyc.push_back(h);
    end
    sendByte(csumByte, $urandom_range(0, maxGap), h);
    repeat (3) @(posedge clk);
    #1;

    checkOutput("write_count", 32'(obsAddr.size() - obsBase), 32'(nWords));
    for (int i = 0; i < nWords && obsBase + i < obsAddr.size(); i++) begin
      checkOutput("write_addr", {24'd0, obsAddr[obsBase+i]}, 32'((int'(base) + i) % 256));
      checkOutput("write_data", {16'd0, obsData[obsBase+i]}, {16'd0, dataQ[2*i], dataQ[2*i+1]});
      checkOutput("write_latency", 32'(obsCyc[obsBase+i] - loCyc[i]), 32'd1);
    end
    checkOutput("done_pulses", 32'(doneCnt - doneBase), badCsum ? 32'd0 : 32'd1);
    checkOutput("err_pulses", 32'(errCnt - errBase), badCsum ? 32'd1 : 32'd0);
    checkOutput("err_code", {30'd0, err_code}, badCsum ? 32'd1 : 32'd0);
    checkOutput("hold_end", {31'd0, cpu_hold}, 32'd0);
    checkOutput("busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic loadBasic(input bit badCsum);
    dataQ = {8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus(8'h02, 8'h10, badCsum, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h;
    int obsBase;
    int errBase;
    int waitN;
    bit seen;
    logic [7:0] b;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wen", {31'd0, ext_mem_wen}, 32'd0);
    checkOutput("rst_addr", {24'd0, ext_mem_addr}, 32'd0);
    checkOutput("rst_data", {16'd0, ext_mem_data}, 32'd0);
    checkOutput("rst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_errcode", {30'd0, err_code}, 32'd0);
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic load");
    loadBasic(1'b0);

    $display("[TB] bad checksum");
    loadBasic(1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("errcode_held", {30'd0, err_code}, 32'd1);

    $display("[TB] address wrap");
    dataQ = {8'h00, 8'h01, 8'h00, 8'h02};
    applyStimulus(8'h02, 8'hFF, 1'b0, 0);

    $display("[TB] preamble garbage");
    obsBase = obsAddr.size();
    #1;
    h = busyCnt;
    sendByte(8'h00, 0, waitN);
    sendByte(8'hFF, 1, waitN);
    sendByte(8'h3C, 0, waitN);
    @(posedge clk);
    #1;
    checkOutput("garbage_writes", 32'(obsAddr.size() - obsBase), 32'd0);
    checkOutput("garbage_busy", 32'(busyCnt - h), 32'd0);
    loadBasic(1'b0);

    $display("[TB] timeout");
    obsBase = obsAddr.size();
    errBase = errCnt;
    sendByte(8'hA5, 0, h);
    sendByte(8'h01, 0, h);
    sendByte(8'h20, 0, h);
    sendByte(8'hAB, 0, h);
    waitN = 0;
    seen = 1'b0;
    while (!seen && waitN < 20) begin
      @(negedge clk);
      waitN++;
      if (err) seen = 1'b1;
    end
    checkOutput("timeout_cycles", 32'(waitN), 32'(TB_TIMEOUT + 1));
    checkOutput("timeout_code", {30'd0, err_code}, 32'd2);
    checkOutput("timeout_hold", {31'd0, cpu_hold}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("timeout_err_pulses", 32'(errCnt - errBase), 32'd1);
    checkOutput("timeout_writes", 32'(obsAddr.size() - obsBase), 32'd0);
    checkOutput("timeout_code_held", {30'd0, err_code}, 32'd2);

    $display("[TB] reset mid-frame");
    obsBase = obsAddr.size();
    sendByte(8'hA5, 0, h);
    sendByte(8'h01, 0, h);
    sendByte(8'h20, 0, h);
    sendByte(8'hAB, 0, h);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_errcode", {30'd0, err_code}, 32'd0);
    checkOutput("mid_rst_addr", {24'd0, ext_mem_addr}, 32'd0);
    checkOutput("mid_rst_data", {16'd0, ext_mem_data}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_rst_writes", 32'(obsAddr.size() - obsBase), 32'd0);
    loadBasic(1'b0);

    $display("[TB] 256-word frame");
    dataQ.delete();
    for (int i = 0; i < 512; i++) dataQ.push_back(8'($urandom));
    applyStimulus(8'h00, 8'($urandom), 1'b0, 0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 12; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        sendByte(b, $urandom_range(0, 2), h);
      end
      dataQ.delete();
      b = 8'($urandom_range(1, 6));
      for (int i = 0; i < 2 * int'(b); i++) dataQ.push_back(randData());
      applyStimulus(b, 8'($urandom), ($urandom % 4) == 0, 3);
    end

    checkOutput("done_err_overlap", 32'(bothCnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
